// File: rtl/demux_1_4_stream.sv
// ---------------------------------------------------------------------------
// demux_1_4_stream
//   Steers one input stream to one of four output lanes. Each lane owns a
//   small FIFO so a stalled consumer never blocks the other three lanes.
//   The lane strobe is decoded through a two-level 1:2 demux tree.
//
//   Optional build macro: DEMUX_AUTO_SEL_EN
//     When defined, in_sel is ignored and an internal round-robin pointer
//     picks the destination lane. The pointer advances on each accepted word
//     and waits on a full lane.
//
// Parameters
//   WIDTH : data width of the input and of each lane
//   DEPTH : entries per lane buffer (2 or 4)
//
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_data/in_sel    : input word and destination lane
//   in_valid/in_ready : input handshake
//   out_data0..3      : head word of each lane (registered)
//   out_valid         : per-lane "holds a word" (registered)
//   out_ready         : per-lane pop request
//   lane_full         : per-lane buffer full (registered)
// ---------------------------------------------------------------------------
module demux_1_4_stream #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [3:0]       lane_full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  if (DEPTH != 2 && DEPTH != 4) begin : g_bad_depth
    $error("demux_1_4_stream: DEPTH must be 2 or 4");
  end

  logic [1:0]       w_sel;
  logic             w_accept;
  logic [1:0]       w_push_l1;
  logic [3:0]       w_push_lane;
  logic [3:0]       w_valid;
  logic [3:0]       w_full;
  logic [WIDTH-1:0] w_head [4];

  // Destination lane: external select or internal round-robin pointer
`ifdef DEMUX_AUTO_SEL_EN
  logic [1:0] r_rr_ptr;
  logic       w_sel_unused;

  assign w_sel_unused = ^in_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= 2'd0;
    end else if (w_accept) begin
      r_rr_ptr <= r_rr_ptr + 2'd1;
    end
  end

  assign w_sel = r_rr_ptr;
`else
  assign w_sel = in_sel;
`endif

  // Ready depends only on registered fullness of the addressed lane
  assign in_ready = !w_full[w_sel];
  assign w_accept = in_valid && in_ready;

  // 1:2 demux tree: upper select bit picks the pair, lower bit the lane
  assign w_push_l1[0]   = w_accept && !w_sel[1];
  assign w_push_l1[1]   = w_accept &&  w_sel[1];
  assign w_push_lane[0] = w_push_l1[0] && !w_sel[0];
  assign w_push_lane[1] = w_push_l1[0] &&  w_sel[0];
  assign w_push_lane[2] = w_push_l1[1] && !w_sel[0];
  assign w_push_lane[3] = w_push_l1[1] &&  w_sel[0];

  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_head;
    logic             r_valid;
    logic             r_full;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] w_count_nxt;
    logic [WIDTH-1:0] w_head_nxt;

    assign w_push = w_push_lane[g];
    assign w_pop  = r_valid && out_ready[g];

    // Next count and next head word; a push into an empty lane or behind the
    // sole popped word becomes the head directly, otherwise the next stored
    // entry moves up.
    always_comb begin
      w_count_nxt = r_count;
      w_head_nxt  = r_head;
      if (w_push && !w_pop) begin
        w_count_nxt = r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        w_count_nxt = r_count - CNT_W'(1);
      end
      if (w_push && (r_count == '0)) begin
        w_head_nxt = in_data;
      end else if (w_pop) begin
        if (r_count > CNT_W'(1)) begin
          w_head_nxt = r_mem[r_rptr + PTR_W'(1)];
        end else if (w_push) begin
          w_head_nxt = in_data;
        end
      end
    end

    // Lane storage, pointers and registered status
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          r_mem[i] <= '0;
        end
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
        r_head  <= '0;
        r_valid <= 1'b0;
        r_full  <= 1'b0;
      end else begin
        if (w_push) begin
          r_mem[r_wptr] <= in_data;
          r_wptr        <= r_wptr + PTR_W'(1);
        end
        if (w_pop) begin
          r_rptr <= r_rptr + PTR_W'(1);
        end
        r_count <= w_count_nxt;
        r_head  <= w_head_nxt;
        r_valid <= (w_count_nxt != '0);
        r_full  <= (w_count_nxt == CNT_W'(DEPTH));
      end
    end

    assign w_valid[g] = r_valid;
    assign w_full[g]  = r_full;
    assign w_head[g]  = r_head;
  end

  assign out_valid = w_valid;
  assign lane_full = w_full;
  assign out_data0 = w_head[0];
  assign out_data1 = w_head[1];
  assign out_data2 = w_head[2];
  assign out_data3 = w_head[3];

endmodule

// File: tb/tb_demux_1_4_stream.sv
// ---------------------------------------------------------------------------
// tb_demux_1_4_stream
//   Drives directed and random traffic into demux_1_4_stream and compares
//   every output against per-lane reference queues.
// ---------------------------------------------------------------------------
module tb_demux_1_4_stream;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DEPTH = 2;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data0, out_data1, out_data2, out_data3;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [3:0]       lane_full;

  demux_1_4_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .lane_full (lane_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [WIDTH-1:0] od [4];
  assign od[0] = out_data0;
  assign od[1] = out_data1;
  assign od[2] = out_data2;
  assign od[3] = out_data3;

  // Reference model: one queue per lane plus the last head seen on each lane
  logic [WIDTH-1:0] q [4][$];
  logic [WIDTH-1:0] last_head [4];
  logic [1:0]       rr;
  int n_checks;
  int n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      q[i].delete();
      last_head[i] = '0;
    end
    rr = 2'd0;
  endtask

  task automatic check_outputs();
    logic [3:0] ev;
    logic [3:0] ef;
    for (int i = 0; i < 4; i++) begin
      ev[i] = (q[i].size() != 0);
      ef[i] = (q[i].size() == DEPTH);
      check($sformatf("out_data%0d", i), 32'(od[i]),
            32'((q[i].size() != 0) ? q[i][0] : last_head[i]));
    end
    check("out_valid", 32'(out_valid), 32'(ev));
    check("lane_full", 32'(lane_full), 32'(ef));
  endtask

  // One bus cycle: check state, drive inputs, check ready, advance model
  task automatic step(input logic v, input logic [1:0] s, input logic [WIDTH-1:0] d,
                      input logic [3:0] r);
    logic [1:0] lane;
    logic       exp_rdy;
    @(negedge clk);
    check_outputs();
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
`ifdef DEMUX_AUTO_SEL_EN
    lane = rr;
`else
    lane = s;
`endif
    exp_rdy = (q[lane].size() < DEPTH);
    #1;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (r[i] && q[i].size() != 0) void'(q[i].pop_front());
    end
    if (v && exp_rdy) begin
      q[lane].push_back(d);
      rr = rr + 2'd1;
    end
    for (int i = 0; i < 4; i++) begin
      if (q[i].size() != 0) last_head[i] = q[i][0];
    end
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = 2'd0;
    in_data   = '0;
    out_ready = 4'b0000;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // 1: one word to each lane, consumers always ready
    step(1'b1, 2'd0, 4'ha, 4'b1111);
    step(1'b1, 2'd1, 4'hb, 4'b1111);
    step(1'b1, 2'd2, 4'hc, 4'b1111);
    step(1'b1, 2'd3, 4'hd, 4'b1111);
    step(1'b0, 2'd0, 4'h0, 4'b1111);
    step(1'b0, 2'd0, 4'h0, 4'b1111);

    // 2: fill lane 2, hold off third word, then drain in order
    step(1'b1, 2'd2, 4'd7,  4'b0000);
    step(1'b1, 2'd2, 4'd10, 4'b0000);
    step(1'b1, 2'd2, 4'd3,  4'b0000);
    step(1'b1, 2'd2, 4'd3,  4'b0100);
    step(1'b1, 2'd2, 4'd3,  4'b0100);
    step(1'b0, 2'd2, 4'd0,  4'b0100);
    step(1'b0, 2'd2, 4'd0,  4'b0100);

    // 3: lane 1 stalled full, other lanes still accept
    step(1'b1, 2'd1, 4'h1, 4'b0000);
    step(1'b1, 2'd1, 4'h2, 4'b0000);
    step(1'b1, 2'd0, 4'h5, 4'b0000);
    step(1'b1, 2'd3, 4'h6, 4'b0000);
    step(1'b0, 2'd0, 4'h0, 4'b1111);
    step(1'b0, 2'd0, 4'h0, 4'b1111);
    step(1'b0, 2'd0, 4'h0, 4'b1111);

    // 4: simultaneous push and pop on a one-entry lane
    step(1'b1, 2'd0, 4'h4, 4'b0000);
    step(1'b1, 2'd0, 4'h9, 4'b0001);
    step(1'b0, 2'd0, 4'h0, 4'b0000);
    step(1'b0, 2'd0, 4'h0, 4'b0001);

    // 5: asynchronous reset between clock edges discards buffered words
    step(1'b1, 2'd0, 4'h3, 4'b0000);
    step(1'b1, 2'd1, 4'h8, 4'b0000);
    step(1'b1, 2'd0, 4'he, 4'b0000);
    step(1'b1, 2'd1, 4'hf, 4'b0000);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 2'd0, 4'h0, 4'b1111);
    step(1'b0, 2'd1, 4'h0, 4'b1111);

`ifdef DEMUX_AUTO_SEL_EN
    // 6: round-robin lane choice, then stall on a full lane
    for (int k = 1; k <= 5; k++) step(1'b1, 2'd0, 4'(k), 4'b1111);
    step(1'b0, 2'd0, 4'h0, 4'b1111);
    for (int k = 0; k < 10; k++) step(1'b1, 2'd0, 4'(k + 6), 4'b0000);
    step(1'b0, 2'd0, 4'h0, 4'b1111);
    step(1'b0, 2'd0, 4'h0, 4'b1111);
    step(1'b0, 2'd0, 4'h0, 4'b1111);
`endif

    // Random traffic with varied consumer back-pressure
    for (int k = 0; k < 400; k++) begin
      logic [3:0] rdy;
      for (int i = 0; i < 4; i++) rdy[i] = ($urandom_range(0, 99) < ((k < 200) ? 35 : 75));
      step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           WIDTH'($urandom), rdy);
    end
    for (int k = 0; k < 4; k++) step(1'b0, 2'd0, 4'h0, 4'b1111);
    @(negedge clk);
    check_outputs();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
